// File: rtl/bank_timing_array.sv
// rtl/bank_timing_array.sv - per-bank DRAM timing tracker with refresh gating and read/write latency lines
// Judges each incoming command against registered state only; rejected commands leave state untouched.
module bank_timing_array #(
  parameter  int BANKS = 16,
  parameter  int CW    = 8,
  parameter  int T_RCD = 22,
  parameter  int T_RP  = 20,
  parameter  int T_RFC = 243,
  parameter  int T_CL  = 14,
  parameter  int T_CWL = 10,
  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  input  logic [BW-1:0]        cmd_bank,
  input  logic                 cmd_ap,
  output logic                 cmd_accept,
  output logic                 cmd_error,
  output logic [2*BANKS-1:0]   bank_state,
  output logic                 refreshing,
  output logic                 rd_valid,
  output logic [BW-1:0]        rd_bank,
  output logic                 wr_req,
  output logic [BW-1:0]        wr_bank
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ACTIVATING  = 2'd1,
    S_ACTIVE      = 2'd2,
    S_PRECHARGING = 2'd3
  } bank_st_t;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;

  bank_st_t          st      [BANKS];
  logic [CW-1:0]     cnt     [BANKS];
  logic [CW-1:0]     ref_cnt;

  logic              rd_v    [T_CL];
  logic [BW-1:0]     rd_b    [T_CL];
  logic              wr_v    [T_CWL];
  logic [BW-1:0]     wr_b    [T_CWL];

  logic              bank_ok;
  bank_st_t          cur;
  logic              any_act;
  logic              all_idle;
  logic              legal;
  logic              push_rd;
  logic              push_wr;

  always_comb begin
    any_act    = 1'b0;
    all_idle   = 1'b1;
    bank_state = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (st[i] == S_ACTIVATING) any_act = 1'b1;
      if (st[i] != S_IDLE)       all_idle = 1'b0;
      bank_state[2*i +: 2] = st[i];
    end
  end

  always_comb begin
    bank_ok = (int'(cmd_bank) < BANKS);
    cur     = bank_ok ? st[cmd_bank] : S_IDLE;
    legal   = 1'b0;
    case (cmd)
      C_NOP:       legal = 1'b1;
      C_ACT:       legal = bank_ok && (cur == S_IDLE) && !refreshing;
      C_RD, C_WR:  legal = bank_ok && (cur == S_ACTIVE) && !refreshing;
      C_PRE:       legal = bank_ok && ((cur == S_ACTIVE) || (cur == S_IDLE)) && !refreshing;
      C_PREA:      legal = !any_act && !refreshing;
      C_REF:       legal = all_idle && !refreshing;
      default:     legal = 1'b0;
    endcase
  end

  assign cmd_accept = cmd_valid && legal;
  assign push_rd    = cmd_accept && (cmd == C_RD);
  assign push_wr    = cmd_accept && (cmd == C_WR);

  assign rd_valid = rd_v[T_CL-1];
  assign rd_bank  = rd_b[T_CL-1];
  assign wr_req   = wr_v[T_CWL-1];
  assign wr_bank  = wr_b[T_CWL-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANKS; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
      end
      refreshing <= 1'b0;
      ref_cnt    <= '0;
      cmd_error  <= 1'b0;
      for (int i = 0; i < T_CL; i++) begin
        rd_v[i] <= 1'b0;
        rd_b[i] <= '0;
      end
      for (int i = 0; i < T_CWL; i++) begin
        wr_v[i] <= 1'b0;
        wr_b[i] <= '0;
      end
    end else begin
      cmd_error <= cmd_valid && !legal;

      // Transitional banks count down; a legal command never targets one, so no conflict below.
      for (int i = 0; i < BANKS; i++) begin
        if (st[i] == S_ACTIVATING || st[i] == S_PRECHARGING) begin
          cnt[i] <= cnt[i] - CW'(1);
          if (cnt[i] == CW'(1))
            st[i] <= (st[i] == S_ACTIVATING) ? S_ACTIVE : S_IDLE;
        end
      end

      if (refreshing) begin
        ref_cnt <= ref_cnt - CW'(1);
        if (ref_cnt == CW'(1)) refreshing <= 1'b0;
      end

      if (cmd_accept) begin
        case (cmd)
          C_ACT: begin
            st[cmd_bank]  <= S_ACTIVATING;
            cnt[cmd_bank] <= CW'(T_RCD - 1);
          end
          C_RD, C_WR: begin
            if (cmd_ap) begin
              st[cmd_bank]  <= S_PRECHARGING;
              cnt[cmd_bank] <= CW'(T_RP - 1);
            end
          end
          C_PRE: begin
            if (cur == S_ACTIVE) begin
              st[cmd_bank]  <= S_PRECHARGING;
              cnt[cmd_bank] <= CW'(T_RP - 1);
            end
          end
          C_PREA: begin
            for (int i = 0; i < BANKS; i++) begin
              if (st[i] == S_ACTIVE) begin
                st[i]  <= S_PRECHARGING;
                cnt[i] <= CW'(T_RP - 1);
              end
            end
          end
          C_REF: begin
            refreshing <= 1'b1;
            ref_cnt    <= CW'(T_RFC - 1);
          end
          default: ;
        endcase
      end

      // Data-phase strobes travel independently of later bank state changes.
      for (int i = T_CL - 1; i > 0; i--) begin
        rd_v[i] <= rd_v[i-1];
        rd_b[i] <= rd_b[i-1];
      end
      rd_v[0] <= push_rd;
      rd_b[0] <= push_rd ? cmd_bank : '0;

      for (int i = T_CWL - 1; i > 0; i--) begin
        wr_v[i] <= wr_v[i-1];
        wr_b[i] <= wr_b[i-1];
      end
      wr_v[0] <= push_wr;
      wr_b[0] <= push_wr ? cmd_bank : '0;
    end
  end

endmodule

// File: tb/tb_bank_timing_array.sv
// tb/tb_bank_timing_array.sv - directed and randomized checks of bank_timing_array
// Reference model tracks each bank as a target kind plus the cycle its transition completes.
module tb_bank_timing_array;

  localparam int BANKS = 16;
  localparam int BW    = 4;
  localparam int CW    = 8;
  localparam int T_RCD = 22;
  localparam int T_RP  = 20;
  localparam int T_RFC = 243;
  localparam int T_CL  = 14;
  localparam int T_CWL = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic [2:0]         cmd;
  logic [BW-1:0]      cmd_bank;
  logic               cmd_ap;
  logic               cmd_accept;
  logic               cmd_error;
  logic [2*BANKS-1:0] bank_state;
  logic               refreshing;
  logic               rd_valid;
  logic [BW-1:0]      rd_bank;
  logic               wr_req;
  logic [BW-1:0]      wr_bank;

  bank_timing_array #(
    .BANKS(BANKS), .CW(CW), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RFC(T_RFC), .T_CL(T_CL), .T_CWL(T_CWL)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
    .cmd_ap(cmd_ap), .cmd_accept(cmd_accept), .cmd_error(cmd_error),
    .bank_state(bank_state), .refreshing(refreshing), .rd_valid(rd_valid),
    .rd_bank(rd_bank), .wr_req(wr_req), .wr_bank(wr_bank)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  logic last_acc;

  int kind [BANKS];
  int until_c [BANKS];
  int ref_until;
  int rd_exp [int];
  int wr_exp [int];
  logic exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mstate(input int b);
    if (cyc < until_c[b]) return (kind[b] != 0) ? 1 : 3;
    return (kind[b] != 0) ? 2 : 0;
  endfunction

  function automatic logic legal_m(input logic [2:0] c, input int b);
    logic rf;
    int s;
    logic any_a;
    logic all_i;
    rf = (cyc < ref_until);
    s = (b < BANKS) ? mstate(b) : -1;
    any_a = 1'b0;
    all_i = 1'b1;
    for (int k = 0; k < BANKS; k++) begin
      if (mstate(k) == 1) any_a = 1'b1;
      if (mstate(k) != 0) all_i = 1'b0;
    end
    case (c)
      3'd0:       return 1'b1;
      3'd1:       return (s == 0) && !rf;
      3'd2, 3'd3: return (s == 2) && !rf;
      3'd4:       return ((s == 0) || (s == 2)) && !rf;
      3'd5:       return !any_a && !rf;
      3'd6:       return all_i && !rf;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < BANKS; k++) begin
      kind[k] = 0;
      until_c[k] = 0;
    end
    ref_until = 0;
    rd_exp.delete();
    wr_exp.delete();
    exp_err = 1'b0;
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] c, input int b, input logic ap);
    logic leg;
    logic [2*BANKS-1:0] ev;
    rst = r; cmd_valid = v; cmd = c; cmd_bank = BW'(b); cmd_ap = ap;
    #2;
    leg = legal_m(c, b);
    chk("cmd_accept", {63'd0, cmd_accept}, {63'd0, v && leg});
    last_acc = cmd_accept;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      exp_err = v && !leg;
      if (v && leg) begin
        case (c)
          3'd1: begin kind[b] = 1; until_c[b] = cyc + T_RCD; end
          3'd2, 3'd3: begin
            if (c == 3'd2) rd_exp[cyc + T_CL] = b;
            else           wr_exp[cyc + T_CWL] = b;
            if (ap) begin kind[b] = 0; until_c[b] = cyc + T_RP; end
          end
          3'd4: if (mstate(b) == 2) begin kind[b] = 0; until_c[b] = cyc + T_RP; end
          3'd5: for (int k = 0; k < BANKS; k++)
                  if (mstate(k) == 2) begin kind[k] = 0; until_c[k] = cyc + T_RP; end
          3'd6: ref_until = cyc + T_RFC;
          default: ;
        endcase
      end
    end
    cyc++;
    ev = '0;
    for (int k = 0; k < BANKS; k++) ev[2*k +: 2] = 2'(mstate(k));
    chk("bank_state", 64'(bank_state), 64'(ev));
    chk("refreshing", {63'd0, refreshing}, {63'd0, cyc < ref_until});
    chk("cmd_error", {63'd0, cmd_error}, {63'd0, exp_err});
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, rd_exp.exists(cyc)});
    if (rd_exp.exists(cyc)) chk("rd_bank", 64'(rd_bank), 64'(rd_exp[cyc]));
    chk("wr_req", {63'd0, wr_req}, {63'd0, wr_exp.exists(cyc)});
    if (wr_exp.exists(cyc)) chk("wr_bank", 64'(wr_bank), 64'(wr_exp[cyc]));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 3'd0, 0, 1'b0);
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic nop_to(input int r);
    while (cyc - base < r) step(1'b0, 1'b0, 3'd0, 0, 1'b0);
  endtask

  initial begin
    int k, b;
    logic v, ap, r;
    logic [2:0] c;
    model_reset();

    // reset values
    do_reset();
    chk("rst_bank_state", 64'(bank_state), 64'd0);
    chk("rst_rd_bank", 64'(rd_bank), 64'd0);
    chk("rst_wr_bank", 64'(wr_bank), 64'd0);

    // ACT then RD one cycle early and on time
    do_reset();
    step(0, 1, 3'd1, 3, 0);  chk("s1_act_acc", {63'd0, last_acc}, 64'd1);
    nop_to(21);              chk("s1_activating21", 64'(bank_state[7:6]), 64'd1);
    step(0, 1, 3'd2, 3, 0);  chk("s1_rd21_rej", {63'd0, last_acc}, 64'd0);
    chk("s1_err22", {63'd0, cmd_error}, 64'd1);
    chk("s1_active22", 64'(bank_state[7:6]), 64'd2);
    step(0, 1, 3'd2, 3, 0);  chk("s1_rd22_acc", {63'd0, last_acc}, 64'd1);
    nop_to(35);              chk("s1_rd_valid35", {63'd0, rd_valid}, 64'd0);
    step(0, 0, 3'd0, 0, 0);  chk("s1_rd_valid36", {63'd0, rd_valid}, 64'd1);
    chk("s1_rd_bank36", 64'(rd_bank), 64'd3);
    step(0, 0, 3'd0, 0, 0);  chk("s1_rd_valid37", {63'd0, rd_valid}, 64'd0);

    // WR with auto-precharge, then ACT on expiry and while Activating
    do_reset();
    step(0, 1, 3'd1, 0, 0);
    nop_to(22);
    step(0, 1, 3'd3, 0, 1);  chk("s2_wrap_acc", {63'd0, last_acc}, 64'd1);
    chk("s2_prech23", 64'(bank_state[1:0]), 64'd3);
    nop_to(32);              chk("s2_wr_req32", {63'd0, wr_req}, 64'd1);
    chk("s2_wr_bank32", 64'(wr_bank), 64'd0);
    nop_to(41);              chk("s2_prech41", 64'(bank_state[1:0]), 64'd3);
    step(0, 1, 3'd1, 0, 0);  chk("s2_act41_rej", {63'd0, last_acc}, 64'd0);
    chk("s2_idle42", 64'(bank_state[1:0]), 64'd0);
    step(0, 1, 3'd1, 0, 0);  chk("s2_act42_acc", {63'd0, last_acc}, 64'd1);
    step(0, 1, 3'd1, 0, 0);  chk("s2_act43_rej", {63'd0, last_acc}, 64'd0);

    // refresh window
    do_reset();
    step(0, 1, 3'd6, 0, 0);  chk("s3_ref_acc", {63'd0, last_acc}, 64'd1);
    nop_to(100);
    step(0, 1, 3'd1, 5, 0);  chk("s3_act100_rej", {63'd0, last_acc}, 64'd0);
    chk("s3_err101", {63'd0, cmd_error}, 64'd1);
    nop_to(242);             chk("s3_ref242", {63'd0, refreshing}, 64'd1);
    step(0, 0, 3'd0, 0, 0);  chk("s3_ref243", {63'd0, refreshing}, 64'd0);
    step(0, 1, 3'd1, 5, 0);  chk("s3_act243_acc", {63'd0, last_acc}, 64'd1);

    // PREA blocked by Activating banks, then accepted
    do_reset();
    step(0, 1, 3'd1, 1, 0);
    step(0, 1, 3'd1, 2, 0);
    nop_to(10);
    step(0, 1, 3'd5, 0, 0);  chk("s4_prea10_rej", {63'd0, last_acc}, 64'd0);
    nop_to(23);
    step(0, 1, 3'd5, 0, 0);  chk("s4_prea23_acc", {63'd0, last_acc}, 64'd1);
    chk("s4_state24", 64'(bank_state), 64'h3C);
    nop_to(43);              chk("s4_state43", 64'(bank_state), 64'd0);

    // reset drops a pending read strobe
    do_reset();
    step(0, 1, 3'd1, 4, 0);
    nop_to(22);
    step(0, 1, 3'd2, 4, 0);  chk("s5_rd_acc", {63'd0, last_acc}, 64'd1);
    nop_to(27);
    step(1, 0, 3'd0, 0, 0);
    rst = 1'b0;
    chk("s5_state28", 64'(bank_state), 64'd0);
    nop_to(36);              chk("s5_no_rd36", {63'd0, rd_valid}, 64'd0);
    chk("s5_rd_bank36", 64'(rd_bank), 64'd0);

    // reserved opcode and WR to an Idle bank
    do_reset();
    step(0, 1, 3'd7, 0, 0);  chk("s6_op7_rej", {63'd0, last_acc}, 64'd0);
    chk("s6_op7_err", {63'd0, cmd_error}, 64'd1);
    step(0, 0, 3'd0, 0, 0);  chk("s6_err_clear", {63'd0, cmd_error}, 64'd0);
    step(0, 1, 3'd3, BANKS-1, 0); chk("s6_wr_rej", {63'd0, last_acc}, 64'd0);
    chk("s6_wr_err", {63'd0, cmd_error}, 64'd1);
    chk("s6_state", 64'(bank_state), 64'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 19);
      if (k < 3)       c = 3'd0;
      else if (k < 8)  c = 3'd1;
      else if (k < 12) c = 3'd2;
      else if (k < 15) c = 3'd3;
      else if (k < 17) c = 3'd4;
      else if (k < 18) c = 3'd5;
      else if (k < 19) c = 3'd6;
      else             c = 3'd7;
      v  = ($urandom_range(0, 9) != 0);
      b  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, BANKS-1) : $urandom_range(0, 3);
      ap = $urandom_range(0, 3) == 0;
      r  = ($urandom_range(0, 499) == 0);
      step(r, v, c, b, ap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_timing_array.md
# bank_timing_array

Parametrised multi-bank DRAM timing tracker for the DDR emulation path. Each of BANKS banks runs an independent Idle/Activating/Active/Precharging state machine gated by tRCD and tRP. A global refresh state is gated by tRFC. Read and write latency pipelines emit data-phase strobes tCL/tCWL cycles after each accepted column command. It sits between the command decoder and the bank storage models, and decides per cycle whether the incoming command is timing-legal.

## Interface
- BANKS, 16, number of banks; BW = $clog2(BANKS), minimum 1
- CW, 8, timing counter width; every T_* parameter must be < 2^CW
- T_RCD, 22, ACT-to-Active cycles (≥2)
- T_RP, 20, PRE-to-Idle cycles (≥2)
- T_RFC, 243, REF-to-Idle cycles (≥2)
- T_CL, 14, RD-to-rd_valid cycles (≥1)
- T_CWL, 10, WR-to-wr_req cycles (≥1)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present this cycle
- cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved (always illegal)
- cmd_bank  in  BW  target bank (ignored by NOP/PREA/REF)
- cmd_ap  in  1  auto-precharge qualifier for RD/WR
- cmd_accept  out  1  combinational: cmd_valid && command legal against current registered state
- cmd_error  out  1  registered one-cycle pulse, cycle after an illegal valid command
- bank_state  out  2*BANKS  per bank {0 Idle, 1 Activating, 2 Active, 3 Precharging}, bank i at [2i+1:2i]
- refreshing  out  1  refresh in progress
- rd_valid, rd_bank  out  1, BW  read data strobe and bank tag
- wr_req, wr_bank  out  1, BW  write data request and bank tag

## Operation
- Legality is judged only on registered state. A command that is rejected changes nothing.
- NOP is always legal.
- ACT: legal iff the target bank is Idle and refreshing=0.
  - Bank goes to Activating, counter loaded with T_RCD-1.
- RD/WR: legal iff the target bank is Active.
  - Pushes bank tag into the read or write delay line.
  - With cmd_ap=1 the bank goes to Precharging, counter loaded with T_RP-1.
  - With cmd_ap=0 the bank stays Active.
- PRE: legal if the target bank is Active (goes to Precharging, counter T_RP-1) or Idle (no effect).
  - Illegal if the target bank is Activating or Precharging.
- PREA: legal iff no bank is Activating and refreshing=0.
  - Every Active bank goes to Precharging. Idle and Precharging banks are unchanged.
- REF: legal iff all banks are Idle and refreshing=0.
  - refreshing=1, global counter loaded with T_RFC-1.
- While refreshing, every command except NOP is illegal.
- Per-bank counter:
  - Decrements each cycle while the bank is in Activating or Precharging.
  - At counter==1, the next state is Active (from Activating) or Idle (from Precharging).
- The refresh counter behaves the same way and clears refreshing at expiry.
- Delay lines are shift registers of depth T_CL and T_CWL holding {valid, bank}. One column command enters per cycle, so back-to-back RDs produce back-to-back rd_valid.
- Reserved opcode 7 and out-of-range cmd_bank (≥BANKS) are illegal.

## Timing
- Reset values:
  - bank_state all 0 (Idle), refreshing=0, cmd_error=0.
  - rd_valid=0, wr_req=0, rd_bank=0, wr_bank=0.
  - All counters 0, delay lines cleared.
- Reset mid-operation: pending rd_valid/wr_req strobes are dropped. No state survives.
- ACT accepted at cycle n: Activating for cycles n+1..n+T_RCD-1, Active at n+T_RCD.
- PRE, PREA or auto-precharge accepted at n: Precharging for cycles n+1..n+T_RP-1, Idle at n+T_RP.
- REF accepted at n: refreshing=1 for cycles n+1..n+T_RFC-1, 0 at n+T_RFC.
- RD accepted at n: rd_valid=1 and rd_bank=tag for exactly cycle n+T_CL.
  - This happens regardless of any later PRE, or auto-precharge, on that bank.
- WR accepted at n: wr_req=1 and wr_bank=tag for exactly cycle n+T_CWL.
- Expiry cycle: a command to a bank whose counter expires this cycle is judged on the current state.
  - Example: ACT to a bank in its last Precharging cycle is rejected and must be retried next cycle.
- cmd_error is asserted in cycle n+1 for an illegal valid command at n. It is never asserted for cmd_valid=0.

## Test plan
- ACT bank 3 at cycle 0, then RD bank 3 at cycles 21 and 22 -> bank_state[7:6]=1 at cycles 1..21 and 2 at cycle 22. RD@21 rejected with cmd_error@22; RD@22 accepted; rd_valid=1 with rd_bank=3 at cycle 36 only.
- ACT bank 0 @0, WR with ap=1 @22, ACT bank 0 @42 and @43 -> wr_req@32 with wr_bank=0; Precharging cycles 23..41, Idle@42. ACT@42 accepted (Idle), ACT@43 rejected because the bank is Activating.
- REF @0 with all banks Idle, ACT bank 5 @100 -> refreshing 1..242; ACT@100 rejected with cmd_error@101; ACT@243 accepted.
- ACT banks 1 and 2 @0/@1, PREA @10 -> PREA rejected (banks Activating). PREA @23 -> banks 1 and 2 Precharging from 24, Idle@43; other banks stay Idle.
- RD bank 4 @n then rst=1 @n+5 -> no rd_valid at n+14; all outputs at reset values from n+6.
- cmd=7 and cmd_bank=BANKS-1 WR to an Idle bank -> each rejected, one-cycle cmd_error, bank_state unchanged.
